// File: rtl/stage_sequencer.sv
// Stage sequencer: 12-TP memory-cycle timing generator with a small stage FSM that
// issues ST1/ST2/DVST/RSTSTG commands and checks the stage-register feedback.
module stage_sequencer (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic GOJAM,
    input  logic REQ_ST1,
    input  logic REQ_ST2,
    input  logic REQ_DV,
    input  logic INKL,
    input  logic ST0_n,
    input  logic ST1_n,
    input  logic ST3_n,
    output logic T01,
    output logic T03,
    output logic T12_n,
    output logic ST1,
    output logic ST2,
    output logic DVST,
    output logic RSTSTG,
    output logic STG_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        SEQ1,
        DV0,
        DV1,
        DV2,
        DV3,
        SEQ2
    } state_t;

    logic [3:0] tpCount_q;
    logic [3:0] tpCount_d;
    state_t     state_q;
    state_t     state_d;
    state_t     pending_q;
    logic       st1_q;
    logic       st2_q;
    logic       dvst_q;
    logic       rststg_q;
    logic       stgErr_q;
    logic       mctEnd;
    logic       enterT03;
    logic       enterT12;
    logic       multiLow;
    logic       stageBad;

    assign tpCount_d = (tpCount_q == 4'd12) ? 4'd1 : tpCount_q + 4'd1;
    assign mctEnd    = (tpCount_q == 4'd12);

    // Anything "at Tn" is sampled on the edge that starts Tn, so the registered
    // command it produces is visible for the whole of Tn.
    assign enterT03  = (tpCount_d == 4'd3);
    assign enterT12  = (tpCount_d == 4'd12);

    assign multiLow  = (!ST0_n && !ST1_n) || (!ST0_n && !ST3_n) || (!ST1_n && !ST3_n);

    always_comb begin
        stageBad = 1'b0;
        case (state_q)
            IDLE, DV0: stageBad = ST0_n | multiLow;
            SEQ1, DV2: stageBad = ST1_n | multiLow;
            DV3:       stageBad = ST3_n | multiLow;
            default:   stageBad = 1'b0;
        endcase
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = pending_q;
            DV0:     state_d = DV1;
            DV1:     state_d = DV2;
            DV2:     state_d = DV3;
            default: state_d = IDLE;
        endcase
    end

    // pending_q holds a request accepted at T12 until the MCT boundary; IDLE means none.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            tpCount_q <= 4'd1;
            state_q   <= IDLE;
            pending_q <= IDLE;
            st1_q     <= 1'b0;
            st2_q     <= 1'b0;
            dvst_q    <= 1'b0;
            rststg_q  <= 1'b0;
            stgErr_q  <= 1'b0;
        end else if (GOJAM) begin
            tpCount_q <= 4'd1;
            state_q   <= IDLE;
            pending_q <= IDLE;
            st1_q     <= 1'b0;
            st2_q     <= 1'b0;
            dvst_q    <= 1'b0;
            rststg_q  <= 1'b1;
            stgErr_q  <= 1'b0;
        end else begin
            tpCount_q <= tpCount_d;
            st1_q     <= 1'b0;
            st2_q     <= 1'b0;
            dvst_q    <= 1'b0;
            rststg_q  <= 1'b0;

            if (mctEnd) begin
                state_q   <= state_d;
                pending_q <= IDLE;
                dvst_q    <= (state_d == DV0) || (state_d == DV1) ||
                             (state_d == DV2) || (state_d == DV3);
            end

            if (enterT12) begin
                case (state_q)
                    IDLE: begin
                        if (!INKL) begin
                            if (REQ_DV) begin
                                pending_q <= DV0;
                            end else if (REQ_ST1) begin
                                pending_q <= SEQ1;
                                st1_q     <= 1'b1;
                            end else if (REQ_ST2) begin
                                pending_q <= SEQ2;
                                st2_q     <= 1'b1;
                            end
                        end
                    end
                    SEQ1, SEQ2, DV3: rststg_q <= 1'b1;
                    DV1:             st1_q    <= 1'b1;
                    default:         ;
                endcase
            end

            if (enterT03 && stageBad) begin
                stgErr_q <= 1'b1;
            end
        end
    end

    assign T01     = (tpCount_q == 4'd1);
    assign T03     = (tpCount_q == 4'd3);
    assign T12_n   = (tpCount_q != 4'd12);
    assign ST1     = st1_q;
    assign ST2     = st2_q;
    assign DVST    = dvst_q;
    assign RSTSTG  = rststg_q;
    assign STG_ERR = stgErr_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a queue-of-MCTs reference model compared every TP,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_stage_sequencer;

    localparam int K_IDLE = 0;
    localparam int K_SEQ1 = 1;
    localparam int K_SEQ2 = 2;
    localparam int K_DV0  = 3;
    localparam int K_DV1  = 4;
    localparam int K_DV2  = 5;
    localparam int K_DV3  = 6;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b0;
    logic GOJAM   = 1'b0;
    logic REQ_ST1 = 1'b0;
    logic REQ_ST2 = 1'b0;
    logic REQ_DV  = 1'b0;
    logic INKL    = 1'b0;
    logic ST0_n   = 1'b0;
    logic ST1_n   = 1'b1;
    logic ST3_n   = 1'b1;
    logic T01, T03, T12_n, ST1, ST2, DVST, RSTSTG, STG_ERR;

    int   checks     = 0;
    int   errors     = 0;
    int   failPrints = 0;

    int   mTp   = 1;
    int   mKind = K_IDLE;
    int   plan[$];
    logic eSt1  = 1'b0;
    logic eSt2  = 1'b0;
    logic eDvst = 1'b0;
    logic eRst  = 1'b0;
    logic eErr  = 1'b0;

    logic compareOn     = 1'b1;
    logic forceSt3High  = 1'b0;
    logic randomFaultOn = 1'b0;

    always #5 SIM_CLK = ~SIM_CLK;

    stage_sequencer dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .GOJAM   (GOJAM),
        .REQ_ST1 (REQ_ST1),
        .REQ_ST2 (REQ_ST2),
        .REQ_DV  (REQ_DV),
        .INKL    (INKL),
        .ST0_n   (ST0_n),
        .ST1_n   (ST1_n),
        .ST3_n   (ST3_n),
        .T01     (T01),
        .T03     (T03),
        .T12_n   (T12_n),
        .ST1     (ST1),
        .ST2     (ST2),
        .DVST    (DVST),
        .RSTSTG  (RSTSTG),
        .STG_ERR (STG_ERR)
    );

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (failPrints < 40) begin
                failPrints++;
                $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
            end
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            if (failPrints < 40) begin
                failPrints++;
                $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
            end
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic st1, input logic st2,
                                 input logic inkl, input logic gojam);
        REQ_DV  = dv;
        REQ_ST1 = st1;
        REQ_ST2 = st2;
        INKL    = inkl;
        GOJAM   = gojam;
    endtask

    // Which active-low stage line must be the (only) low one at T03; -1 means unchecked.
    function automatic int requiredLine(input int kind);
        case (kind)
            K_IDLE, K_DV0: return 0;
            K_SEQ1, K_DV2: return 1;
            K_DV3:         return 3;
            default:       return -1;
        endcase
    endfunction

    // Reference model: each MCT has a kind; an accepted request queues the list of MCTs
    // its sequence occupies, and the last queued MCT ends with RSTSTG.
    task automatic modelStep();
        int lows;
        int need;
        logic lineHigh;
        eSt1  = 1'b0;
        eSt2  = 1'b0;
        eDvst = 1'b0;
        eRst  = 1'b0;
        if (!SIM_RST) begin
            mTp   = 1;
            mKind = K_IDLE;
            plan.delete();
            eErr  = 1'b0;
        end else if (GOJAM) begin
            mTp   = 1;
            mKind = K_IDLE;
            plan.delete();
            eRst  = 1'b1;
            eErr  = 1'b0;
        end else begin
            if (mTp == 12) begin
                mTp   = 1;
                mKind = (plan.size() > 0) ? plan.pop_front() : K_IDLE;
                eDvst = (mKind >= K_DV0) && (mKind <= K_DV3);
            end else begin
                mTp = mTp + 1;
            end
            if (mTp == 12) begin
                if (mKind == K_IDLE) begin
                    if (!INKL) begin
                        if (REQ_DV) begin
                            plan.push_back(K_DV0);
                            plan.push_back(K_DV1);
                            plan.push_back(K_DV2);
                            plan.push_back(K_DV3);
                        end else if (REQ_ST1) begin
                            plan.push_back(K_SEQ1);
                            eSt1 = 1'b1;
                        end else if (REQ_ST2) begin
                            plan.push_back(K_SEQ2);
                            eSt2 = 1'b1;
                        end
                    end
                end else begin
                    if (plan.size() == 0) eRst = 1'b1;
                    if (mKind == K_DV1)   eSt1 = 1'b1;
                end
            end
            if (mTp == 3) begin
                need = requiredLine(mKind);
                lows = int'(!ST0_n) + int'(!ST1_n) + int'(!ST3_n);
                lineHigh = (need == 0) ? ST0_n : (need == 1) ? ST1_n : ST3_n;
                if (need >= 0 && (lineHigh || lows > 1)) eErr = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge SIM_CLK or negedge SIM_RST);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge SIM_CLK);
            if (compareOn) begin
                checkOutput("T01",     T01,     mTp == 1);
                checkOutput("T03",     T03,     mTp == 3);
                checkOutput("T12_n",   T12_n,   mTp != 12);
                checkOutput("ST1",     ST1,     eSt1);
                checkOutput("ST2",     ST2,     eSt2);
                checkOutput("DVST",    DVST,    eDvst);
                checkOutput("RSTSTG",  RSTSTG,  eRst);
                checkOutput("STG_ERR", STG_ERR, eErr);
            end
        end
    end

    // Stage feedback follows the MCT kind, with optional deliberate faults.
    initial begin
        forever begin
            @(negedge SIM_CLK);
            {ST0_n, ST1_n, ST3_n} = 3'b111;
            case (mKind)
                K_IDLE, K_DV0: ST0_n = 1'b0;
                K_SEQ1, K_DV2: ST1_n = 1'b0;
                K_DV3:         ST3_n = forceSt3High;
                default:       {ST0_n, ST1_n, ST3_n} = 3'($urandom_range(0, 7));
            endcase
            if (randomFaultOn && mTp == 2 && $urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ST0_n = ~ST0_n;
                    1:       ST1_n = ~ST1_n;
                    default: ST3_n = ~ST3_n;
                endcase
            end
        end
    end

    task automatic waitIdleTp(input int k);
        int n;
        n = 0;
        while (!(mTp == k && mKind == K_IDLE) && n < 40) begin
            @(negedge SIM_CLK);
            n++;
        end
        checkOutput("waitIdleTp reached", (mTp == k && mKind == K_IDLE), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t01Cnt, firstT01, lastT01, t12Cnt, firstT12;
        int dvstCnt, dvstSum, firstDvst, st1Cnt, st1Off, rstCnt, rstOff;
        int pulseCnt;
        t01Cnt = 0; firstT01 = 0; lastT01 = 0; t12Cnt = 0; firstT12 = 0;
        dvstCnt = 0; dvstSum = 0; firstDvst = -1; st1Cnt = 0; st1Off = -1;
        rstCnt = 0; rstOff = -1; pulseCnt = 0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge SIM_CLK);
        checkOutput("reset T01",     T01,     1'b1);
        checkOutput("reset T03",     T03,     1'b0);
        checkOutput("reset T12_n",   T12_n,   1'b1);
        checkOutput("reset RSTSTG",  RSTSTG,  1'b0);
        checkOutput("reset STG_ERR", STG_ERR, 1'b0);

        SIM_RST = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge SIM_CLK);
            if (k == 1) checkOutput("first edge leaves TP1", T01, 1'b0);
            if (k == 2) checkOutput("second edge reaches TP3", T03, 1'b1);
            if (T01) begin
                t01Cnt++;
                if (firstT01 == 0) firstT01 = k;
                lastT01 = k;
            end
            if (!T12_n) begin
                t12Cnt++;
                if (firstT12 == 0) firstT12 = k;
            end
        end
        checkCount("T01 pulses in 30 TPs", t01Cnt, 2);
        checkCount("first T01 edge", firstT01, 12);
        checkCount("T01 spacing", lastT01 - firstT01, 12);
        checkCount("T12_n lows in 30 TPs", t12Cnt, 2);
        checkCount("first T12 edge", firstT12, 11);

        waitIdleTp(11);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge SIM_CLK);
        checkOutput("ST1 at accepting T12", ST1, 1'b1);
        checkOutput("T12_n at accept", T12_n, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge SIM_CLK);
            if (i == 1) checkOutput("ST1 one TP only", ST1, 1'b0);
        end
        checkOutput("RSTSTG at T12 of SEQ1", RSTSTG, 1'b1);
        checkOutput("STG_ERR after SEQ1", STG_ERR, 1'b0);

        waitIdleTp(11);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int off = 0; off <= 50; off++) begin
            if (DVST) begin
                dvstCnt++;
                dvstSum += off;
                if (firstDvst < 0) firstDvst = off;
            end
            if (ST1) begin
                st1Cnt++;
                st1Off = off;
            end
            if (RSTSTG) begin
                rstCnt++;
                rstOff = off;
            end
            @(negedge SIM_CLK);
        end
        checkCount("DV DVST count", dvstCnt, 4);
        checkCount("DV DVST first offset", firstDvst, 1);
        checkCount("DV DVST offset sum", dvstSum, 76);
        checkCount("DV ST1 count", st1Cnt, 1);
        checkCount("DV ST1 offset", st1Off, 24);
        checkCount("DV RSTSTG count", rstCnt, 1);
        checkCount("DV RSTSTG offset", rstOff, 48);
        checkOutput("DV STG_ERR", STG_ERR, 1'b0);

        forceSt3High = 1'b1;
        waitIdleTp(11);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int off = 1; off <= 55; off++) begin
            @(negedge SIM_CLK);
            if (off == 38) checkOutput("STG_ERR before DV3 T03", STG_ERR, 1'b0);
            if (off == 39) checkOutput("STG_ERR at DV3 T03", STG_ERR, 1'b1);
            if (off == 55) checkOutput("STG_ERR sticky", STG_ERR, 1'b1);
        end
        forceSt3High = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("GOJAM clears STG_ERR", STG_ERR, 1'b0);
        checkOutput("GOJAM RSTSTG", RSTSTG, 1'b1);

        waitIdleTp(11);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("GOJAM mid-DV2 T01", T01, 1'b1);
        checkOutput("GOJAM mid-DV2 RSTSTG", RSTSTG, 1'b1);
        checkOutput("GOJAM mid-DV2 DVST", DVST, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge SIM_CLK);
            pulseCnt += int'(DVST) + int'(ST1) + int'(ST2) + int'(RSTSTG);
        end
        waitIdleTp(11);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("INKL blocks ST1", ST1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            @(negedge SIM_CLK);
            pulseCnt += int'(DVST) + int'(ST1) + int'(ST2) + int'(RSTSTG);
        end
        checkCount("pulses after GOJAM", pulseCnt, 0);

        waitIdleTp(11);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge SIM_CLK);
        @(posedge SIM_CLK);
        #2;
        SIM_RST = 1'b0;
        #1;
        checkOutput("async reset T01", T01, 1'b1);
        checkOutput("async reset T03", T03, 1'b0);
        checkOutput("async reset T12_n", T12_n, 1'b1);
        checkOutput("async reset DVST", DVST, 1'b0);
        checkOutput("async reset ST1", ST1, 1'b0);
        repeat (2) @(negedge SIM_CLK);
        SIM_RST = 1'b1;

        randomFaultOn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge SIM_CLK);
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 149) == 0);
        end
        @(negedge SIM_CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge SIM_CLK);
        compareOn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
